env_uart_tx: RTL and testbench
==============================

Name: env_uart_tx

Overview:
Testbench-side console transmitter on the TV80 I/O bus. It sits alongside the I/O environment block and consumes Z80 OUT cycles to a small port window. Bytes written to its data port are queued in a FIFO and serialized 8N1 on `txd`, so a UART monitor or an external model can capture program output. It also exposes control and status registers and a TX-empty interrupt level for interrupt tests.

Parameters:
- BASE_ADDR, 8'h88: I/O port of the DATA register. CTRL is at BASE_ADDR+1 and STATUS at BASE_ADDR+2.
- FIFO_DEPTH, 16: FIFO entries. Must be a power of 2, maximum 16.
- CLKS_PER_BIT, 16: `clk` cycles per serial bit. Minimum 2.

Ports:
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `iorq_n`, input, 1: Z80 I/O request.
- `rd_n`, input, 1: Z80 read strobe.
- `wr_n`, input, 1: Z80 write strobe.
- `addr`, input, 8: I/O port address.
- `d_out`, input, 8: CPU write data.
- `rd_data`, output, 8: register read data (combinational).
- `rd_valid`, output, 1: high when `rd_data` must be driven onto DI.
- `txd`, output, 1: serial output; idle level is 1.
- `irq`, output, 1: TX-empty interrupt level.

Behaviour:
Reset
- `txd`=1, `irq`=0, FIFO empty.
- CTRL=8'h00, so TX is disabled. Overflow flag=0. FSM in IDLE.
- Reset mid-frame aborts the frame immediately; `txd`=1 on the next cycle.

Write detection
- `wr_stb` = !`iorq_n` & !`wr_n`. It is registered into `last_wr`.
- `addr`/`d_out` are captured on every cycle where `wr_stb` is high.
- A write commits on the edge where `last_wr`=1 and `wr_stb`=0 (trailing edge), using the captured values.
- Exactly one commit happens per bus cycle.

DATA write (BASE_ADDR)
- The byte is pushed if count < FIFO_DEPTH, or if a pop occurs on the same edge.
- Otherwise the byte is dropped and overflow is set (sticky).

CTRL write (BASE_ADDR+1)
- bit0 tx_en.
- bit1 irq_en.
- bit6 clear overflow (self-clearing).
- bit7 flush (self-clearing): empties the FIFO and clears overflow. An in-flight frame completes.
- Bits 0–1 are stored; bits 6–7 always read as 0.

Reads
- `rd_valid` = !`iorq_n` & !`rd_n` & (`addr`==BASE_ADDR+1 | `addr`==BASE_ADDR+2).
- CTRL reads back {6'b0, irq_en, tx_en}.
- STATUS = {overflow, busy, full, count[4:0]}.
- DATA is write-only: reads give `rd_valid`=0, `rd_data`=8'h00.
- Reads have no side effects.

TX FSM
- States: IDLE, START, DATA, STOP. A bit counter (0..CLKS_PER_BIT-1) and a bit index (0..7) run alongside.
- IDLE: `txd`=1. If tx_en and FIFO not empty, pop the head into the shift register and go to START. `txd`=0 from the next edge.
- START: `txd`=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: shift out LSB first, each bit held CLKS_PER_BIT cycles. After bit 7, go to STOP.
- STOP: `txd`=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Back-to-back bytes therefore have exactly 1 idle cycle between the STOP and the next START.
- Frame length is 10*CLKS_PER_BIT cycles.
- Clearing tx_en mid-frame finishes the current frame and blocks further pops.
- busy = (state != IDLE).

Latency and flags
- Enabled, empty, idle case: a DATA commit at edge E causes `txd` to fall at edge E+2 (pop at E+1).
- full = (count == FIFO_DEPTH).
- count is the FIFO occupancy only; it excludes the byte being shifted.
- `irq` is registered: `irq` = irq_en & (count==0) & !busy.
- A simultaneous flush and DATA push: flush wins, so the pushed byte is discarded.

Decomposition:
- Package `env_uart_pkg`:
  - FSM state enum.
  - Register offsets DATA/CTRL/STATUS.
  - CTRL bit positions: TX_EN, IRQ_EN, OVF_CLR, FLUSH.
  - STATUS bit positions.
- Sub-module `env_sync_fifo` (parameters WIDTH, DEPTH):
  - Inputs: push, pop, flush.
  - Outputs: count, full, empty, head.
  - Same `clk`/`reset`.
- The top level holds bus decode, registers and the TX FSM.

Test Plan:
1. CLKS_PER_BIT=4. Write CTRL=8'h01, then DATA=8'h55 → `txd` is 0,1,0,1,0,1,0,1,0,1, each held 4 cycles (40 cycles total). The falling edge occurs 2 edges after the commit. busy returns to 0.
2. TX disabled, 17 DATA writes → STATUS reads 8'hB0 (overflow=1, full=1, count=16). The 17th byte is not in the FIFO. CTRL write 8'h40 → STATUS reads 8'h30.
3. Fill 3 bytes (8'h41, 8'h42, 8'h43), then enable → three frames go out in order. There is exactly 1 idle cycle between the STOP of one frame and the START of the next. count steps 3→2→1→0.
4. CTRL=8'h03 with the FIFO empty → `irq`=1. A DATA write drops `irq` within 1 cycle of the commit. `irq` returns to 1 one cycle after the last STOP completes.
5. Frame in progress plus 2 queued bytes, write CTRL=8'h80 (flush) → the current frame completes and no further frames are sent. STATUS count=0, overflow=0.
6. Assert `reset` during DATA bit 3 → `txd`=1 on the next cycle, STATUS=8'h00, CTRL=8'h00. After reset deasserts, no frame is sent.

Source files
------------

// File: rtl/env_uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : env_uart_pkg
// Description : Shared types and constants for the env_uart_tx console
//               transmitter: TX FSM states, register offsets, bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package env_uart_pkg;

  // Serial frame state machine
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  // Register offsets from the base port
  localparam logic [7:0] OFS_DATA   = 8'd0;
  localparam logic [7:0] OFS_CTRL   = 8'd1;
  localparam logic [7:0] OFS_STATUS = 8'd2;

  // CTRL bit positions
  localparam int CTRL_TX_EN   = 0;
  localparam int CTRL_IRQ_EN  = 1;
  localparam int CTRL_OVF_CLR = 6;
  localparam int CTRL_FLUSH   = 7;

  // STATUS bit positions (count occupies bits 4:0)
  localparam int STAT_OVF  = 7;
  localparam int STAT_BUSY = 6;
  localparam int STAT_FULL = 5;

  // Assemble the STATUS byte from its fields
  function automatic logic [7:0] pack_status(input logic ovf, input logic busy,
                                             input logic full, input logic [4:0] count);
    logic [7:0] s;
    s            = {3'b000, count};
    s[STAT_OVF]  = ovf;
    s[STAT_BUSY] = busy;
    s[STAT_FULL] = full;
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/env_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : env_sync_fifo
// Description : Small synchronous FIFO with flush. DEPTH must be a power of
//               two between 2 and 16; count is reported on 5 bits.
// Revision    : 1.0 - initial release
// ============================================================================
module env_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [4:0]       count,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is still accepted when a pop frees a slot on the same edge
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign full  = (count == 5'(DEPTH));
  assign empty = (count == 5'd0);
  assign head  = mem[rd_ptr];

  // Pointer and occupancy tracking; flush takes priority over push/pop
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 5'd0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage array, written without reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/env_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : env_uart_tx
// Description : Testbench-side console UART transmitter on the TV80 I/O bus.
//               OUT cycles to the DATA port queue bytes that are sent 8N1 on
//               txd; CTRL/STATUS registers and a TX-empty interrupt level.
// Revision    : 1.0 - initial release
// ============================================================================
module env_uart_tx
  import env_uart_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR    = 8'h88,
  parameter int         FIFO_DEPTH   = 16,
  parameter int         CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iorq_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic [7:0] addr,
  input  logic [7:0] d_out,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       txd,
  output logic       irq
);

  localparam int            CW          = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST    = CW'(CLKS_PER_BIT - 1);
  localparam logic [7:0]    ADDR_DATA   = BASE_ADDR + OFS_DATA;
  localparam logic [7:0]    ADDR_CTRL   = BASE_ADDR + OFS_CTRL;
  localparam logic [7:0]    ADDR_STATUS = BASE_ADDR + OFS_STATUS;

  logic          wr_stb;
  logic          rd_stb;
  logic          last_wr;
  logic [7:0]    cap_addr;
  logic [7:0]    cap_data;
  logic          commit;
  logic          data_wr;
  logic          ctrl_wr;
  logic          flush;
  logic          tx_en;
  logic          irq_en;
  logic          overflow;
  logic          fifo_pop;
  logic [4:0]    fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_head;
  tx_state_t     state;
  logic [CW-1:0] bit_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  // The write commits on the trailing edge of the strobe using captured bus values
  assign wr_stb  = !iorq_n && !wr_n;
  assign rd_stb  = !iorq_n && !rd_n;
  assign commit  = last_wr && !wr_stb;
  assign data_wr = commit && (cap_addr == ADDR_DATA);
  assign ctrl_wr = commit && (cap_addr == ADDR_CTRL);
  assign flush   = ctrl_wr && cap_data[CTRL_FLUSH];

  // A new frame starts only from IDLE with TX enabled and a byte waiting
  assign fifo_pop = (state == ST_IDLE) && tx_en && !fifo_empty;

  env_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (data_wr),
    .pop   (fifo_pop),
    .flush (flush),
    .din   (cap_data),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  // Track the write strobe and capture address/data while it is asserted
  always_ff @(posedge clk) begin
    if (reset) begin
      last_wr  <= 1'b0;
      cap_addr <= 8'h00;
      cap_data <= 8'h00;
    end else begin
      last_wr <= wr_stb;
      if (wr_stb) begin
        cap_addr <= addr;
        cap_data <= d_out;
      end
    end
  end

  // CTRL register and sticky overflow flag
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_en    <= 1'b0;
      irq_en   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        tx_en  <= cap_data[CTRL_TX_EN];
        irq_en <= cap_data[CTRL_IRQ_EN];
      end
      if (ctrl_wr && (cap_data[CTRL_OVF_CLR] || cap_data[CTRL_FLUSH])) begin
        overflow <= 1'b0;
      end else if (data_wr && fifo_full && !fifo_pop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Serializer: txd is registered from the current state, one cycle behind it
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      bit_idx <= 3'd0;
      shreg   <= 8'h00;
      txd     <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          txd     <= 1'b1;
          bit_cnt <= '0;
          bit_idx <= 3'd0;
          if (fifo_pop) begin
            shreg <= fifo_head;
            state <= ST_START;
          end
        end
        ST_START: begin
          txd <= 1'b0;
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            state   <= ST_DATA;
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        ST_DATA: begin
          txd <= shreg[0];
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            shreg   <= {1'b0, shreg[7:1]};
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        ST_STOP: begin
          txd <= 1'b1;
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            state   <= ST_IDLE;
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        default: begin
          txd   <= 1'b1;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // TX-empty interrupt level
  always_ff @(posedge clk) begin
    if (reset) begin
      irq <= 1'b0;
    end else begin
      irq <= irq_en && (fifo_count == 5'd0) && (state == ST_IDLE);
    end
  end

  assign rd_valid = rd_stb && ((addr == ADDR_CTRL) || (addr == ADDR_STATUS));

  // Register read mux; DATA is write-only and reads as zero
  always_comb begin
    rd_data = 8'h00;
    if (rd_stb && (addr == ADDR_CTRL)) begin
      rd_data = {6'b000000, irq_en, tx_en};
    end else if (rd_stb && (addr == ADDR_STATUS)) begin
      rd_data = pack_status(overflow, state != ST_IDLE, fifo_full, fifo_count);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_env_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_env_uart_tx
// Description : Self-checking bench for env_uart_tx. Bus writes feed an
//               expected-byte queue; a UART receiver process decodes txd and
//               compares each frame against it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_env_uart_tx;

  localparam int         CPB      = 4;
  localparam int         DEPTH    = 16;
  localparam logic [7:0] BASE     = 8'h88;
  localparam logic [7:0] A_DATA   = BASE;
  localparam logic [7:0] A_CTRL   = BASE + 8'd1;
  localparam logic [7:0] A_STATUS = BASE + 8'd2;
  localparam int         FRAME    = 10 * CPB;

  logic       clk    = 1'b0;
  logic       reset  = 1'b1;
  logic       iorq_n = 1'b1;
  logic       rd_n   = 1'b1;
  logic       wr_n   = 1'b1;
  logic [7:0] addr   = 8'h00;
  logic [7:0] d_out  = 8'h00;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       txd;
  logic       irq;

  env_uart_tx #(
    .BASE_ADDR    (BASE),
    .FIFO_DEPTH   (DEPTH),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .iorq_n   (iorq_n),
    .rd_n     (rd_n),
    .wr_n     (wr_n),
    .addr     (addr),
    .d_out    (d_out),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .txd      (txd),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  int         n_checks     = 0;
  int         n_fail       = 0;
  int         cyc          = 0;
  int         reset_cycles = 0;
  int         frame_starts = 0;
  int         start_cyc[$];
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (reset) reset_cycles <= reset_cycles + 1;

  // Serial level of bit i of an 8N1 frame carrying b
  function automatic logic frame_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i == 9) return 1'b1;
    return b[i-1];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic io_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; d_out = d; iorq_n = 1'b0; wr_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    iorq_n = 1'b1; wr_n = 1'b1;
    @(posedge clk);
  endtask

  task automatic io_read(input logic [7:0] a, output logic [7:0] d, output logic v);
    @(negedge clk);
    addr = a; iorq_n = 1'b0; rd_n = 1'b0;
    #1;
    d = rd_data;
    v = rd_valid;
    @(negedge clk);
    iorq_n = 1'b1; rd_n = 1'b1;
  endtask

  task automatic rd_check(input string name, input logic [7:0] a,
                          input logic [7:0] exp_d, input logic exp_v);
    logic [7:0] d;
    logic       v;
    io_read(a, d, v);
    check(name, 32'(d), 32'(exp_d));
    check({name, "_valid"}, 32'(v), 32'(exp_v));
  endtask

  // Poll until every expected byte has been received and the transmitter is idle and empty
  task automatic wait_drain(input string name);
    logic [7:0] s;
    logic       v;
    int         t;
    t = 0;
    while (t < 4000) begin
      io_read(A_STATUS, s, v);
      if (exp_q.size() == 0 && s[6] == 1'b0 && s[4:0] == 5'd0) break;
      t++;
    end
    check({name, "_drain_timeout"}, 32'(t < 4000), 1);
  endtask

  task automatic wait_frames(input int target, input string name);
    int t;
    t = 0;
    while (frame_starts < target && t < 1000) begin
      @(posedge clk);
      t++;
    end
    check({name, "_frame_timeout"}, 32'(frame_starts >= target), 1);
  endtask

  // UART receiver / scoreboard: decode each frame mid-bit and compare with the queue
  initial begin : monitor
    logic [7:0] b;
    logic [7:0] e;
    logic       start_ok;
    logic       stop_ok;
    int         rc0;
    forever begin
      @(negedge clk);
      if (txd !== 1'b0 || reset) continue;
      frame_starts++;
      start_cyc.push_back(cyc);
      rc0 = reset_cycles;
      repeat (CPB / 2) @(negedge clk);
      start_ok = (txd === 1'b0);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        b[i] = txd;
      end
      repeat (CPB) @(negedge clk);
      stop_ok = (txd === 1'b1);
      if (reset_cycles != rc0) continue;
      check("frame_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("frame_byte", 32'(b), 32'(e));
        check("frame_start_bit", 32'(start_ok), 1);
        check("frame_stop_bit", 32'(stop_ok), 1);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, got %0d checks, expected completion", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [7:0] d;
    logic [7:0] exp_s;
    int         f0;
    int         n;
    int         acc;
    int         ns;

    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    check("reset_txd", 32'(txd), 1);
    check("reset_irq", 32'(irq), 0);
    rd_check("reset_status", A_STATUS, 8'h00, 1'b1);
    rd_check("reset_ctrl", A_CTRL, 8'h00, 1'b1);
    rd_check("data_read", A_DATA, 8'h00, 1'b0);

    // Single 0x55 frame: txd high one edge after commit, low two edges after, 40-cycle waveform
    io_write(A_CTRL, 8'h01);
    io_write(A_DATA, 8'h55);
    exp_q.push_back(8'h55);
    @(posedge clk); #1;
    check("latency_e1_txd", 32'(txd), 1);
    for (int i = 0; i < FRAME; i++) begin
      @(posedge clk); #1;
      check("frame55_level", 32'(txd), 32'(frame_bit(8'h55, i / CPB)));
    end
    wait_drain("t1");
    rd_check("t1_status_idle", A_STATUS, 8'h00, 1'b1);
    io_write(A_CTRL, 8'h00);

    // Random fills with TX disabled; first round overfills by one byte
    for (int r = 0; r < 4; r++) begin
      n   = (r == 0) ? DEPTH + 1 : int'($urandom_range(1, 20));
      acc = 0;
      for (int k = 0; k < n; k++) begin
        d = 8'($urandom);
        io_write(A_DATA, d);
        if (acc < DEPTH) begin
          exp_q.push_back(d);
          acc++;
        end
      end
      exp_s = {(n > DEPTH) ? 1'b1 : 1'b0, 1'b0, (acc == DEPTH) ? 1'b1 : 1'b0, 5'(acc)};
      rd_check("fill_status", A_STATUS, exp_s, 1'b1);
      if (n > DEPTH) begin
        io_write(A_CTRL, 8'h40);
        rd_check("ovf_clr_status", A_STATUS, 8'h30, 1'b1);
      end
      io_write(A_CTRL, 8'h01);
      wait_drain("round");
      rd_check("round_status", A_STATUS, 8'h00, 1'b1);
      io_write(A_CTRL, 8'h00);
    end

    // Three queued bytes sent back-to-back, one idle cycle between frames
    io_write(A_DATA, 8'h41); exp_q.push_back(8'h41);
    io_write(A_DATA, 8'h42); exp_q.push_back(8'h42);
    io_write(A_DATA, 8'h43); exp_q.push_back(8'h43);
    rd_check("t3_count3", A_STATUS, 8'h03, 1'b1);
    f0 = frame_starts;
    io_write(A_CTRL, 8'h01);
    repeat (2) @(posedge clk);
    rd_check("t3_count2", A_STATUS, 8'h42, 1'b1);
    wait_frames(f0 + 2, "t3_second");
    rd_check("t3_count1", A_STATUS, 8'h41, 1'b1);
    wait_frames(f0 + 3, "t3_third");
    rd_check("t3_count0", A_STATUS, 8'h40, 1'b1);
    wait_drain("t3");
    ns = start_cyc.size();
    check("t3_spacing_1_2", 32'(start_cyc[ns-2] - start_cyc[ns-3]), 32'(FRAME + 1));
    check("t3_spacing_2_3", 32'(start_cyc[ns-1] - start_cyc[ns-2]), 32'(FRAME + 1));
    io_write(A_CTRL, 8'h00);

    // TX-empty interrupt: pop one edge after commit, busy for one frame, irq one cycle after
    io_write(A_CTRL, 8'h03);
    repeat (2) @(posedge clk); #1;
    check("t4_irq_idle", 32'(irq), 1);
    d = 8'($urandom);
    io_write(A_DATA, d);
    exp_q.push_back(d);
    @(posedge clk); #1;
    check("t4_irq_drop", 32'(irq), 0);
    repeat (FRAME) @(posedge clk); #1;
    check("t4_irq_last_stop", 32'(irq), 0);
    @(posedge clk); #1;
    check("t4_irq_return", 32'(irq), 1);
    wait_drain("t4");
    io_write(A_CTRL, 8'h01);
    repeat (2) @(posedge clk); #1;
    check("t4_irq_disabled", 32'(irq), 0);

    // Flush of a full, overflowed FIFO discards everything and sends nothing
    io_write(A_CTRL, 8'h00);
    for (int k = 0; k < DEPTH + 1; k++) io_write(A_DATA, 8'($urandom));
    rd_check("t5_full_status", A_STATUS, 8'hB0, 1'b1);
    io_write(A_CTRL, 8'h80);
    rd_check("t5_flush_status", A_STATUS, 8'h00, 1'b1);
    rd_check("t5_flush_ctrl", A_CTRL, 8'h00, 1'b1);
    f0 = frame_starts;
    io_write(A_CTRL, 8'h01);
    repeat (60) @(posedge clk);
    check("t5_no_frames", 32'(frame_starts), 32'(f0));

    // Flush while a frame is in flight: it completes, queued bytes never go out
    f0 = frame_starts;
    d = 8'($urandom);
    io_write(A_DATA, d);
    exp_q.push_back(d);
    io_write(A_DATA, 8'($urandom));
    io_write(A_DATA, 8'($urandom));
    io_write(A_CTRL, 8'h81);
    rd_check("t5_inflight_status", A_STATUS, 8'h40, 1'b1);
    wait_drain("t5");
    repeat (2 * FRAME) @(posedge clk);
    check("t5_one_frame", 32'(frame_starts), 32'(f0 + 1));
    rd_check("t5_final_status", A_STATUS, 8'h00, 1'b1);

    // Reset during data bit 3 (a zero bit) forces txd high and clears all state
    d = 8'($urandom) & 8'hF7;
    io_write(A_DATA, d);
    repeat (19) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check("t6_txd_after_reset", 32'(txd), 1);
    @(negedge clk) reset = 1'b0;
    rd_check("t6_status", A_STATUS, 8'h00, 1'b1);
    rd_check("t6_ctrl", A_CTRL, 8'h00, 1'b1);
    f0 = frame_starts;
    repeat (100) @(posedge clk); #1;
    check("t6_no_frame", 32'(frame_starts), 32'(f0));
    check("t6_txd_idle", 32'(txd), 1);
    check("t6_queue_empty", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
